instruction_fetch_ctrl: RTL
===========================

# instruction_fetch_ctrl

Fetch controller that drives the program counter's control interface (Inc_PC, Load_PC, load data) and consumes its count output. It issues one instruction-memory read per PC value over a req/ack handshake, holds the returned word in an instruction register offered to the decoder with valid/ready, and redirects the PC on branch requests. It sits between the program counter, instruction memory and the decode stage of the MCU.

## Interface
- data_size, 8, address/PC width
- instr_size, 16, instruction word width
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- run  in  1  fetch enable
- pc_count  in  data_size  current PC value
- Inc_PC  out  1  PC increment strobe
- Load_PC  out  1  PC load strobe
- pc_data_out  out  data_size  PC load value
- mem_req  out  1  memory read request
- mem_addr  out  data_size  memory read address
- mem_ack  in  1  read data valid, single-cycle pulse
- mem_rdata  in  instr_size  read data
- ir_valid  out  1  instruction register holds a word
- ir_ready  in  1  decoder accepts the word
- ir_data  out  instr_size  fetched instruction
- ir_pc  out  data_size  address the instruction came from
- branch_req  in  1  redirect pulse
- branch_target  in  data_size  redirect address

## Operation
- States: IDLE, FETCH, STEP, LOAD. Moore outputs: mem_req=1 only in FETCH; Inc_PC=1 only in STEP; Load_PC=1 only in LOAD.
- Reset: state IDLE, all outputs 0, pending-branch flag and discard flag cleared; mem_req drops asynchronously.
- IDLE: if branch pending → LOAD. Else if run and (ir_valid=0 or ir_ready=1) → FETCH, register mem_addr<=pc_count.
- FETCH: mem_req and mem_addr held stable until mem_ack. On mem_ack: if discard=0, ir_data<=mem_rdata, ir_pc<=mem_addr, ir_valid<=1, → STEP; if discard=1, drop data, clear discard, → LOAD. mem_ack outside FETCH ignored.
- STEP: one cycle, → LOAD if branch pending, else IDLE.
- LOAD: pc_data_out=pending target, one cycle, clear pending, → IDLE.
- IR handshake: ir_valid&ir_ready at an edge clears ir_valid (unless capture at same edge). A request issues only with IR empty or being consumed, so capture never overwrites an unconsumed word.
- Branch (branch_req=1 at an edge, any state): ir_valid<=0 (flush), pending<=1, target<=branch_target. In FETCH, the bus transaction completes (no abandon) with discard<=1. In LOAD, newer target replaces; LOAD repeats one cycle. Branch beats run and ir_ready in same cycle.
- run=0: no new request; in-flight fetch completes normally.
- pc_data_out holds last target outside LOAD (0 after reset).

## Timing
- Edge 0: IDLE→FETCH, mem_req=1. mem_ack in cycle k → edge k: ir_valid=1, STEP. Next edge: PC increments, IDLE. Minimum 3 cycles per instruction with zero-wait memory.
- Next request uses pc_count only after Inc_PC has taken effect (never issued in STEP).
- Branch to first request of new target: 2 cycles from IDLE (LOAD, IDLE→FETCH).
- Reset mid-FETCH: request withdrawn immediately; memory must tolerate.

## Structure
- Shared package: state encoding localparams S_IDLE=2'd0, S_FETCH=2'd1, S_STEP=2'd2, S_LOAD=2'd3; data_size/instr_size defaults.
- Single module; no sub-module.

## Test plan
- Reset, pc_count=0x00, run=1, memory acks 1 cycle after req with 0xA5A5 → mem_addr=0x00, ir_data=0xA5A5, ir_pc=0x00, one Inc_PC pulse, next request at 0x01.
- ir_ready=0 for 10 cycles with ir_valid=1 → no mem_req, ir_data stable, no Inc_PC.
- branch_req to 0x40 in IDLE with ir_valid=1 → ir_valid=0 next edge, Load_PC=1 with pc_data_out=0x40 one cycle, next mem_addr=0x40.
- branch_req to 0x80 during FETCH, ack 3 cycles later with 0x1234 → mem_req held, data discarded, no Inc_PC, Load_PC with 0x80, ir_valid stays 0.
- pc_count=0xFF fetch → ir_pc=0xFF, Inc_PC pulse, next request at 0x00 (wrap in PC).
- rst low mid-FETCH → mem_req, ir_valid, Inc_PC, Load_PC all 0 immediately; resumes from pc_count after release.

Source files
------------

// File: rtl/instruction_fetch_ctrl_pkg.sv
// instruction_fetch_ctrl_pkg: shared sizes and fetch FSM state encoding
//   default_data_size  - PC / address width
//   default_instr_size - instruction word width
//   S_*                - fetch FSM state codes
package instruction_fetch_ctrl_pkg;
  localparam int default_data_size = 8;
  localparam int default_instr_size = 16;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_STEP = 2'd2;
  localparam logic [1:0] S_LOAD = 2'd3;
endpackage

// File: rtl/instruction_fetch_ctrl.sv
// instruction_fetch_ctrl: fetches one word per PC value into an instruction register and redirects the PC on branches
//   clk, rst (async, active-low)
//   run                          - fetch enable
//   pc_count / Inc_PC / Load_PC / pc_data_out  - program counter control
//   mem_req / mem_addr / mem_ack / mem_rdata   - instruction memory read handshake
//   ir_valid / ir_ready / ir_data / ir_pc      - decoder handshake
//   branch_req / branch_target                 - redirect request
module instruction_fetch_ctrl
  import instruction_fetch_ctrl_pkg::*;
#(
  parameter int data_size = default_data_size,
  parameter int instr_size = default_instr_size
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [data_size-1:0]  pc_count,
  output logic                  Inc_PC,
  output logic                  Load_PC,
  output logic [data_size-1:0]  pc_data_out,
  output logic                  mem_req,
  output logic [data_size-1:0]  mem_addr,
  input  logic                  mem_ack,
  input  logic [instr_size-1:0] mem_rdata,
  output logic                  ir_valid,
  input  logic                  ir_ready,
  output logic [instr_size-1:0] ir_data,
  output logic [data_size-1:0]  ir_pc,
  input  logic                  branch_req,
  input  logic [data_size-1:0]  branch_target
);
  logic [1:0] state, state_next;
  logic pending, discard, capture;
  logic [data_size-1:0] target;
  // a branch at the ack edge flushes the returning word just like a pending discard
  assign capture = state == S_FETCH && mem_ack && !discard && !branch_req;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= S_IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  state_next = (pending || branch_req) ? S_LOAD : (run && (!ir_valid || ir_ready)) ? S_FETCH : S_IDLE;
      S_FETCH: state_next = !mem_ack ? S_FETCH : (discard || branch_req) ? S_LOAD : S_STEP;
      S_STEP:  state_next = (pending || branch_req) ? S_LOAD : S_IDLE;
      default: state_next = branch_req ? S_LOAD : S_IDLE;
    endcase
  end
  always_comb begin
    mem_req = state == S_FETCH;
    Inc_PC = state == S_STEP;
    Load_PC = state == S_LOAD;
    pc_data_out = target;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pending <= 1'b0;
      discard <= 1'b0;
      target <= '0;
      mem_addr <= '0;
      ir_valid <= 1'b0;
      ir_data <= '0;
      ir_pc <= '0;
    end else begin
      pending <= branch_req || (pending && state != S_LOAD);
      // the bus transaction is never abandoned; a redirect mid-fetch only marks the reply as stale
      discard <= state == S_FETCH && (mem_ack ? 1'b0 : (discard || branch_req));
      if (branch_req) target <= branch_target;
      if (state == S_IDLE && state_next == S_FETCH) mem_addr <= pc_count;
      if (capture) begin
        ir_data <= mem_rdata;
        ir_pc <= mem_addr;
      end
      ir_valid <= !branch_req && (capture || (ir_valid && !ir_ready));
    end
endmodule
